// File: rtl/seq_link_pkg.sv
// Shared widths, LFSR constants and helpers for the sequence link checker.
package seq_link_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned GAP_W_DEF  = 8;
  localparam int unsigned GAP_EXT_W  = GAP_W_DEF + 1;
  localparam int unsigned LFSR_W     = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 16'hACE1;

  // Fibonacci LFSR, taps 16,14,13,11; a non-zero seed never reaches zero.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Idle gap in [from, to]; an empty or inverted range pins the gap to 'from'.
  function automatic logic [GAP_W_DEF-1:0] calc_gap(
    input logic [GAP_W_DEF-1:0] from,
    input logic [GAP_W_DEF-1:0] to,
    input logic [GAP_W_DEF-1:0] rnd
  );
    logic [GAP_EXT_W-1:0] range_p1;
    logic [GAP_EXT_W-1:0] sum;
    if (to <= from) begin
      return from;
    end
    range_p1 = GAP_EXT_W'(to) - GAP_EXT_W'(from) + GAP_EXT_W'(1);
    sum      = GAP_EXT_W'(from) + (GAP_EXT_W'(rnd) % range_p1);
    return GAP_W_DEF'(sum);
  endfunction

endpackage

// File: rtl/seq_link_receiver.sv
// Scoreboard: checks strobed words against a running expected counter.
// STICKY_FAILURE_EN: when defined, failure latches until reset.
module seq_link_receiver
  import seq_link_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_expected,
  output logic              o_failure
);

  logic [DATA_W-1:0] r_expected;
  logic              r_failure;
  logic              w_mismatch;

  assign w_mismatch = i_en && (i_data != r_expected);

  // Resynchronise to the received word and flag any mismatch one cycle later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_expected <= '0;
      r_failure  <= 1'b0;
    end else begin
      if (i_en) begin
        r_expected <= i_data + DATA_W'(1);
      end
`ifdef STICKY_FAILURE_EN
      r_failure <= r_failure | w_mismatch;
`else
      r_failure <= w_mismatch;
`endif
    end
  end

  assign o_expected = r_expected;
  assign o_failure  = r_failure;

endmodule

// File: rtl/seq_link_sender.sv
// Traffic source: incrementing words as one-cycle strobes with random idle gaps.
module seq_link_sender
  import seq_link_pkg::*;
#(
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter int unsigned       GAP_W     = GAP_W_DEF,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [GAP_W-1:0]  i_gap_from,
  input  logic [GAP_W-1:0]  i_gap_to,
  output logic [DATA_W-1:0] o_data,
  output logic              o_en
);

  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_data;
  logic              r_en;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [LFSR_W-1:0] r_lfsr;
  logic [GAP_W-1:0]  w_gap;

  // Gap for the next idle run, only consumed on issue cycles.
  assign w_gap = calc_gap(i_gap_from, i_gap_to, r_lfsr[GAP_W-1:0]);

  // Issue a word when the gap counter is empty, otherwise count the idle run down.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx      <= '0;
      r_data    <= '0;
      r_en      <= 1'b0;
      r_gap_cnt <= '0;
      r_lfsr    <= LFSR_SEED;
    end else if (r_gap_cnt == '0) begin
      r_en      <= 1'b1;
      r_data    <= r_tx;
      r_tx      <= r_tx + DATA_W'(1);
      r_gap_cnt <= w_gap;
      r_lfsr    <= lfsr_next(r_lfsr);
    end else begin
      r_en      <= 1'b0;
      r_gap_cnt <= r_gap_cnt - GAP_W'(1);
    end
  end

  assign o_data = r_data;
  assign o_en   = r_en;

endmodule

// File: rtl/seq_link_checker.sv
// Same-clock link exerciser: sender feeding receiver scoreboard.
// STICKY_FAILURE_EN: when defined, failure latches until reset.
module seq_link_checker
  import seq_link_pkg::*;
#(
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter int unsigned       GAP_W     = GAP_W_DEF,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GAP_W-1:0]  gap_from,
  input  logic [GAP_W-1:0]  gap_to,
  output logic [DATA_W-1:0] data,
  output logic              en,
  output logic [DATA_W-1:0] expected,
  output logic              failure
);

  logic [DATA_W-1:0] w_data;
  logic              w_en;

  seq_link_sender #(
    .DATA_W   (DATA_W),
    .GAP_W    (GAP_W),
    .LFSR_SEED(LFSR_SEED)
  ) u_sender (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_gap_from(gap_from),
    .i_gap_to  (gap_to),
    .o_data    (w_data),
    .o_en      (w_en)
  );

  seq_link_receiver #(
    .DATA_W(DATA_W)
  ) u_receiver (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (w_en),
    .i_data    (w_data),
    .o_expected(expected),
    .o_failure (failure)
  );

  assign data = w_data;
  assign en   = w_en;

endmodule

// File: tb/tb_seq_link_checker.sv
// Bench for seq_link_checker plus a standalone seq_link_receiver instance.
module tb_seq_link_checker;

`ifdef STICKY_FAILURE_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] gap_from = 8'd5;
  logic [7:0] gap_to   = 8'd5;
  logic [3:0] data;
  logic       en;
  logic [3:0] expected;
  logic       failure;

  logic       rx_rst  = 1'b1;
  logic       rx_en   = 1'b0;
  logic [3:0] rx_data = 4'd0;
  logic [3:0] rx_expected;
  logic       rx_failure;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state, plain integers.
  int m_tx, m_left, m_lfsr, m_data, m_exp;
  bit m_en, m_fail;

  // Idle-run bookkeeping.
  int idle_cnt, phase_strobes, run_lo, run_hi;
  int seen_mask;
  bit found;

  always #5 clk = ~clk;

  seq_link_checker dut (
    .clk     (clk),
    .rst     (rst),
    .gap_from(gap_from),
    .gap_to  (gap_to),
    .data    (data),
    .en      (en),
    .expected(expected),
    .failure (failure)
  );

  seq_link_receiver rx (
    .i_clk     (clk),
    .i_rst     (rx_rst),
    .i_en      (rx_en),
    .i_data    (rx_data),
    .o_expected(rx_expected),
    .o_failure (rx_failure)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_gap(input int from, input int to, input int lfsr);
    if (to <= from) return from;
    return from + ((lfsr & 255) % (to - from + 1));
  endfunction

  // Advance the reference by one clock edge using the inputs the DUT sampled.
  task automatic model_edge();
    bit mm;
    if (rst) begin
      m_tx = 0; m_left = 0; m_lfsr = 'hACE1; m_en = 0; m_data = 0; m_exp = 0; m_fail = 0;
    end else begin
      // Scoreboard: after any strobe the receiver expects that word plus one.
      mm = m_en && (m_data != m_exp);
      m_fail = STICKY ? (m_fail || mm) : mm;
      if (m_en) m_exp = (m_data + 1) % 16;
      if (m_left == 0) begin
        m_en = 1; m_data = m_tx; m_tx = (m_tx + 1) % 16;
        m_left = ref_gap(int'(gap_from), int'(gap_to), m_lfsr);
        m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1)) & 'hFFFF;
      end else begin
        m_en = 0; m_left--;
      end
    end
  endtask

  // One clock: update model at the edge, compare top outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("en", 32'(en), 32'(m_en));
    chk("data", 32'(data), 32'(m_data));
    chk("expected", 32'(expected), 32'(m_exp));
    chk("failure", 32'(failure), 32'(0));
    if (!rst && en) begin
      if (phase_strobes > 0) begin
        chk("idle_run_in_range", 32'((idle_cnt >= run_lo) && (idle_cnt <= run_hi)), 32'(1));
        seen_mask |= (1 << (idle_cnt & 31));
      end
      phase_strobes++;
      idle_cnt = 0;
    end else begin
      idle_cnt++;
    end
  endtask

  task automatic set_gap(input int from, input int to);
    gap_from = 8'(from);
    gap_to   = 8'(to);
    run_lo = from;
    run_hi = (to <= from) ? from : to;
    phase_strobes = 0;
    idle_cnt = 0;
    seen_mask = 0;
  endtask

  task automatic count_bits(input int v, output int n);
    n = 0;
    for (int i = 0; i < 32; i++) n += (v >> i) & 1;
  endtask

  initial begin
    int n, fr, to;
    set_gap(5, 5);

    // Reset state
    step();
    chk("reset_lfsr_model_zero_data", 32'(data), 32'(0));
    rst = 1'b0;

    // Fixed gap 5: strobes every 6th cycle, data 0..8
    for (int i = 0; i < 50; i++) step();
    chk("gap5_last_data", 32'(m_data), 32'(8));
    count_bits(seen_mask, n);
    chk("gap5_single_run_len", 32'(n), 32'(1));

    // Gap 0: strobe every cycle, data wraps 15->0
    set_gap(0, 0);
    for (int i = 0; i < 50; i++) step();
    chk("gap0_en_high", 32'(en), 32'(1));

    // Random gap in 0..10, need variety
    set_gap(0, 10);
    for (int i = 0; i < 50; i++) step();
    count_bits(seen_mask, n);
    chk("gap0_10_distinct_ge2", 32'(n >= 2), 32'(1));

    // Inverted range pins gap to gap_from
    set_gap(7, 3);
    for (int i = 0; i < 50; i++) step();

    // Randomized ranges
    for (int p = 0; p < 4; p++) begin
      fr = int'($urandom_range(0, 12));
      to = int'($urandom_range(0, 12));
      set_gap(fr, to);
      for (int i = 0; i < 40; i++) step();
    end

    // Reset mid-stream when data 9 is strobed
    set_gap(2, 2);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (en && data == 4'd9) found = 1;
    end
    chk("found_data9", 32'(found), 32'(1));
    rst = 1'b1;
    step();
    chk("midrst_expected_before", 32'(expected), 32'(0));
    rst = 1'b0;
    set_gap(2, 2);
    step();
    chk("midrst_first_en", 32'(en), 32'(1));
    chk("midrst_first_data", 32'(data), 32'(0));
    chk("midrst_failure", 32'(failure), 32'(0));
    for (int i = 0; i < 10; i++) step();

    // Standalone receiver: strobes 0,1,5,6 then idle
    @(negedge clk); rx_rst = 1'b0; rx_en = 1'b1; rx_data = 4'd0;
    @(negedge clk);
    chk("rx_exp_after0", 32'(rx_expected), 32'(1));
    chk("rx_fail_after0", 32'(rx_failure), 32'(0));
    rx_data = 4'd1;
    @(negedge clk);
    chk("rx_exp_after1", 32'(rx_expected), 32'(2));
    chk("rx_fail_after1", 32'(rx_failure), 32'(0));
    rx_data = 4'd5;
    @(negedge clk);
    chk("rx_exp_after5", 32'(rx_expected), 32'(6));
    chk("rx_fail_after5", 32'(rx_failure), 32'(1));
    rx_data = 4'd6;
    @(negedge clk);
    chk("rx_exp_after6", 32'(rx_expected), 32'(7));
    chk("rx_fail_after6", 32'(rx_failure), 32'(STICKY));
    rx_en = 1'b0;
    @(negedge clk);
    chk("rx_exp_idle", 32'(rx_expected), 32'(7));
    chk("rx_fail_idle", 32'(rx_failure), 32'(STICKY));
    rx_rst = 1'b1;
    @(negedge clk);
    chk("rx_fail_reset", 32'(rx_failure), 32'(0));
    chk("rx_exp_reset", 32'(rx_expected), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
